requant_pipe: RTL and testbench
===============================

// Module: requant_pipe
// PURPOSE
// - Per-channel fixed-point requantization of 32-bit conv/FC accumulators to 8-bit activations.
// - Fully pipelined, one result per clock, with valid/ready back-pressure.
// - Generalises the single-shot quantizer:
//   - per-channel multiplier and shift, loaded at run time;
//   - rounding doubling high multiply with saturation;
//   - zero-point add and activation clamp.
// - Sits between the MAC array accumulator output and the maxpooling / output buffer.
// PARAMETERS
// ACC_W    32     accumulator width (signed)
// OUT_W    8      output activation width (signed)
// NUM_CH   16     channels with independent multiplier/shift
// CH_W     4      channel index width, clog2(NUM_CH)
// ACT_MIN  -128   clamp lower bound
// ACT_MAX  127    clamp upper bound
// PORTS
// clk        in   1       clock; all state updates on posedge
// rst        in   1       asynchronous, active-high reset
// cfg_we     in   1       write one channel entry of the config table
// cfg_ch     in   CH_W    channel written
// cfg_mult   in   32      signed Q31 multiplier (reset value 2014687024)
// cfg_shift  in   5       right shift exponent, 0..31 (reset value 8)
// cfg_zp     in   OUT_W   signed output zero point (reset value 0)
// in_valid   in   1       accumulator sample valid
// in_ready   out  1       block accepts the sample this cycle
// in_acc     in   ACC_W   signed accumulator
// in_ch      in   CH_W    channel of in_acc
// out_valid  out  1       result valid
// out_ready  in   1       downstream accepts result
// out_q      out  OUT_W   signed quantized result
// out_ch     out  CH_W    channel tag, carried with the data
// BEHAVIOUR
// - Reset:
//   - out_valid=0, out_q=0, out_ch=0, all stage valids=0;
//   - every table entry = {2014687024, 8, 0};
//   - in_ready=1 once rst deasserts.
// - Transfer occurs on valid&&ready at either port.
// - Latency: 4 cycles from input transfer to out_valid with no stall. Throughput 1/clk.
// - Stall: global enable en = !out_valid || out_ready; in_ready = en.
//   - When en=0, every stage holds, including data and valid bits.
// - S1: look up cfg[in_ch]; P = in_acc * mult as signed 64 bits; latch shift, zp, ch.
// - S2: doubling high mul X = (P + nudge) / 2^31, truncated toward zero.
//   - nudge = P>=0 ? 2^30 : 1-2^30.
//   - If in_acc==INT32_MIN and mult==INT32_MIN, X = 2^31-1 (saturate).
// - S3: rounding divide by 2^shift:
//   - mask = 2^shift-1, rem = X & mask, thr = (mask>>1) + (X<0);
//   - Y = (X>>>shift) + (rem>thr).
//   - shift=0 gives Y=X.
// - S4: Z = Y + zp, computed in 33 bits; out_q = clamp(Z, ACT_MIN, ACT_MAX).
// - Config writes:
//   - take effect for samples accepted on the cycle after cfg_we;
//   - a sample in flight keeps the values latched at S1;
//   - a write to the channel being read in the same cycle does not affect that sample.
// - cfg_ch >= NUM_CH: write ignored. in_ch >= NUM_CH: uses entry 0.
// - Reset mid-stream: in-flight samples are dropped; the table returns to defaults.
// STRUCTURE
// - Shared package (requant_pkg):
//   - Q31 constants (2^30, 2^31-1, INT32_MIN);
//   - default multiplier, shift and zero point;
//   - stage payload struct {data, shift, zp, ch, valid}.
// - Sub-module requant_cfg_table: NUM_CH x (32+5+OUT_W) register file.
//   - one write port, one combinational read port; async reset to defaults.
// - Top holds the 4 stage registers and the en/stall logic.
//   - The multiplier maps to DSP and is registered in S1.
// TESTING
// - Defaults, ch0, acc=1000 -> out_q=4 after 4 clks (X=938, rem=170>127 rounds up).
// - Defaults, acc=-1000 -> X=-938, rem=86, thr=128 -> out_q=-4.
// - cfg ch3 = {mult=INT32_MIN, shift=0, zp=0}; acc=INT32_MIN -> X saturates; out_q=127.
// - cfg ch1 = {2014687024, 0, -128}; acc=1000 -> Z=810 -> out_q=127.
//   - Same config, acc=-1000 -> out_q=-128.
// - Back-pressure: stream 20 samples on ch0..3, out_ready toggling randomly.
//   - No loss or duplication; order kept; out_ch matches; in_ready low exactly when stalled.
// - Assert rst with 3 samples in flight -> out_valid=0 the same cycle.
//   - After release, ch0 = default config (acc=1000 -> 4).
//   - cfg_we on the cycle of an in_ch read -> the old value applies to that sample.

Source files
------------

// File: rtl/requant_pkg.sv
// Shared definitions for the requantization pipeline: widths, Q31 constants,
// per-channel config defaults, the config entry and stage payload structs, and
// the final activation clamp.
package requant_pkg;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned NUM_CH = 16;
  localparam int unsigned CH_W   = 4;
  localparam int          ACT_MIN = -128;
  localparam int          ACT_MAX = 127;

  // Q31 constants, held at product width
  localparam logic signed [63:0] Q30       = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] Q31_MAX   = 64'sh0000_0000_7FFF_FFFF;
  localparam logic        [31:0] INT32_MIN = 32'h8000_0000;
  // INT32_MIN * INT32_MIN is the only product that reaches +2^62
  localparam logic signed [63:0] P_SAT     = 64'sh4000_0000_0000_0000;

  localparam logic [31:0]      DEF_MULT  = 32'd2014687024;
  localparam logic [4:0]       DEF_SHIFT = 5'd8;
  localparam logic [OUT_W-1:0] DEF_ZP    = '0;

  typedef struct packed {
    logic [31:0]      mult;
    logic [4:0]       shift;
    logic [OUT_W-1:0] zp;
  } cfg_entry_t;

  // data holds P in S1 and the sign-extended 32-bit X / Y in later stages
  typedef struct packed {
    logic [63:0]      data;
    logic [4:0]       shift;
    logic [OUT_W-1:0] zp;
    logic [CH_W-1:0]  ch;
    logic             valid;
  } stage_t;

  function automatic logic [OUT_W-1:0] clamp_act(input logic signed [32:0] z);
    if (z < 33'(ACT_MIN)) begin
      return OUT_W'(ACT_MIN);
    end else if (z > 33'(ACT_MAX)) begin
      return OUT_W'(ACT_MAX);
    end
    return z[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/requant_cfg_table.sv
// Per-channel requantization config register file.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (entries -> defaults)
//   cfg_we/cfg_ch        write strobe and channel; out-of-range channels are ignored
//   cfg_mult/shift/zp    entry written
//   rd_ch                combinational read channel; out-of-range reads entry 0
//   rd_mult/shift/zp     entry read
module requant_cfg_table import requant_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [31:0]      cfg_mult,
  input  logic [4:0]       cfg_shift,
  input  logic [OUT_W-1:0] cfg_zp,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [31:0]      rd_mult,
  output logic [4:0]       rd_shift,
  output logic [OUT_W-1:0] rd_zp
);

  cfg_entry_t      tbl_q [NUM_CH];
  logic            wr_ok;
  logic [CH_W-1:0] rd_idx;

  // Range checks only exist when the index can exceed the table
  if (NUM_CH < (1 << CH_W)) begin : g_partial
    assign wr_ok  = (32'(cfg_ch) < NUM_CH);
    assign rd_idx = (32'(rd_ch) < NUM_CH) ? rd_ch : '0;
  end else begin : g_full
    assign wr_ok  = 1'b1;
    assign rd_idx = rd_ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        tbl_q[i] <= '{mult: DEF_MULT, shift: DEF_SHIFT, zp: DEF_ZP};
      end
    end else if (cfg_we && wr_ok) begin
      tbl_q[cfg_ch] <= '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp};
    end
  end

  assign rd_mult  = tbl_q[rd_idx].mult;
  assign rd_shift = tbl_q[rd_idx].shift;
  assign rd_zp    = tbl_q[rd_idx].zp;

endmodule

// File: rtl/requant_pipe.sv
// Four-stage per-channel requantizer: 32-bit accumulator -> 8-bit activation.
//   S1 product with per-channel multiplier, S2 rounding doubling high multiply,
//   S3 rounding right shift, S4 zero-point add and clamp (output register).
// One global enable stalls every stage when the output is held.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cfg_we/ch/mult/shift/zp          run-time config table write
//   in_valid/in_ready/in_acc/in_ch   accumulator input handshake
//   out_valid/out_ready/out_q/out_ch quantized result handshake
module requant_pipe import requant_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [31:0]      cfg_mult,
  input  logic [4:0]       cfg_shift,
  input  logic [OUT_W-1:0] cfg_zp,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_q,
  output logic [CH_W-1:0]  out_ch
);

  logic [31:0]      rd_mult;
  logic [4:0]       rd_shift;
  logic [OUT_W-1:0] rd_zp;
  logic             en;

  stage_t s1_q, s2_q, s3_q;
  stage_t s1_d, s2_d, s3_d;
  logic [OUT_W-1:0] q_d;

  requant_cfg_table u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .rd_ch     (in_ch),
    .rd_mult   (rd_mult),
    .rd_shift  (rd_shift),
    .rd_zp     (rd_zp)
  );

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: signed 32x32 product; sign-extended operands give the exact low 64 bits
  always_comb begin
    s1_d       = '0;
    s1_d.data  = {{32{in_acc[31]}}, in_acc} * {{32{rd_mult[31]}}, rd_mult};
    s1_d.shift = rd_shift;
    s1_d.zp    = rd_zp;
    s1_d.ch    = in_ch;
    s1_d.valid = in_valid;
  end

  // S2: X = (P + nudge) / 2^31 truncated toward zero
  logic signed [63:0] p2, nudge2, sum2, adj2, xs2;
  logic        [31:0] x2;

  always_comb begin
    p2     = $signed(s1_q.data);
    nudge2 = p2[63] ? (64'sd1 - Q30) : Q30;
    sum2   = p2 + nudge2;
    // bias negatives so the arithmetic shift truncates toward zero
    adj2   = sum2[63] ? (sum2 + Q31_MAX) : sum2;
    xs2    = adj2 >>> 31;
    x2     = (p2 == P_SAT) ? Q31_MAX[31:0] : xs2[31:0];
    s2_d      = s1_q;
    s2_d.data = {{32{x2[31]}}, x2};
  end

  // S3: divide by 2^shift, rounding half away from zero
  logic signed [31:0] x3, x3_sh;
  logic        [31:0] mask3, rem3, thr3, y3;

  always_comb begin
    x3    = $signed(s2_q.data[31:0]);
    mask3 = (32'd1 << s2_q.shift) - 32'd1;
    rem3  = x3 & mask3;
    thr3  = (mask3 >> 1) + {31'b0, x3[31]};
    x3_sh = x3 >>> s2_q.shift;
    y3    = x3_sh + {31'b0, (rem3 > thr3)};
    s3_d      = s2_q;
    s3_d.data = {{32{y3[31]}}, y3};
  end

  // S4: zero point and clamp
  logic signed [32:0] z4;

  always_comb begin
    z4  = $signed({s3_q.data[31], s3_q.data[31:0]})
        + $signed({{(33 - OUT_W){s3_q.zp[OUT_W-1]}}, s3_q.zp});
    q_d = clamp_act(z4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_ch    <= '0;
    end else if (en) begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      out_valid <= s3_q.valid;
      out_q     <= q_d;
      out_ch    <= s3_q.ch;
    end
  end

  // Upper halves are sign copies and S4 has no use for the shift
  logic unused_bits;
  assign unused_bits = ^{xs2[63:32], s2_q.data[63:32], s3_q.data[63:32], s3_q.shift};

endmodule

// File: tb/tb_requant_pipe.sv
module tb_requant_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_ch;
  logic [31:0] cfg_mult;
  logic [4:0] cfg_shift;
  logic [7:0] cfg_zp;
  logic       in_valid;
  logic       in_ready;
  logic [31:0] in_acc;
  logic [3:0] in_ch;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_q;
  logic [3:0] out_ch;

  always #5 clk = ~clk;

  requant_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_ch    (out_ch)
  );

  int ntotal = 0;
  int nbad   = 0;

  // bench-side copy of the config table
  logic [31:0] m_mult [16];
  int          m_shift [16];
  logic [7:0]  m_zp [16];

  typedef struct {
    string      name;
    logic [3:0] ch;
    logic [31:0] acc;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mirror_defaults();
    for (int i = 0; i < 16; i++) begin
      m_mult[i]  = 32'd2014687024;
      m_shift[i] = 8;
      m_zp[i]    = 8'd0;
    end
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [31:0] mult,
                           input logic [4:0] sh, input logic [7:0] zp);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mult = mult; cfg_shift = sh; cfg_zp = zp;
    tick();
    cfg_we = 1'b0;
    m_mult[ch] = mult; m_shift[ch] = int'(sh); m_zp[ch] = zp;
  endtask

  // Reference: round-half-away-from-zero formulation of the rounding shift
  function automatic logic [7:0] model(input logic [31:0] acc, input logic [3:0] ch);
    longint p, x, y, z, h;
    int     sh;
    sh = m_shift[ch];
    p  = longint'($signed(acc)) * longint'($signed(m_mult[ch]));
    if (acc == 32'h8000_0000 && m_mult[ch] == 32'h8000_0000) x = 64'sd2147483647;
    else if (p >= 0) x = (p + 64'sd1073741824) / 64'sd2147483648;
    else             x = (p + 64'sd1 - 64'sd1073741824) / 64'sd2147483648;
    if (sh == 0) y = x;
    else begin
      h = 64'sd1 <<< (sh - 1);
      y = (x >= 0) ? ((x + h) >>> sh) : -((-x + h) >>> sh);
    end
    z = y + longint'($signed(m_zp[ch]));
    if (z < -128) z = -128;
    if (z > 127)  z = 127;
    return z[7:0];
  endfunction

  // Waits for the result of a sample whose transfer edge has just passed
  task automatic wait_out(input string name, input logic [3:0] ch, input logic [7:0] exp);
    int n;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'd4);
    check({name, "_q"}, 64'(out_q), 64'(exp));
    check({name, "_ch"}, 64'(out_ch), 64'(ch));
    tick();
  endtask

  task automatic run_vec(input string name, input logic [3:0] ch, input logic [31:0] acc,
                         input logic [7:0] exp);
    in_valid = 1'b1; in_ch = ch; in_acc = acc;
    tick();
    in_valid = 1'b0;
    wait_out(name, ch, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_q [$];
    logic [3:0]  exp_ch [$];
    logic [3:0]  vm;
    logic        exp_en;
    int          sent, got, bad_drop;

    vecs[0]  = '{"d_p1000",   4'd0,  32'd1000,         8'd4};
    vecs[1]  = '{"d_n1000",   4'd0, -32'sd1000,        8'hFC};
    vecs[2]  = '{"d_zero",    4'd0,  32'd0,            8'd0};
    vecs[3]  = '{"d_p137",    4'd0,  32'd137,          8'd1};
    vecs[4]  = '{"d_tie_p",   4'd0,  32'd136,          8'd1};
    vecs[5]  = '{"d_tie_n",   4'd0, -32'sd136,         8'hFF};
    vecs[6]  = '{"sat_min",   4'd3,  32'h8000_0000,    8'd127};
    vecs[7]  = '{"zp_hi",     4'd1,  32'd1000,         8'd127};
    vecs[8]  = '{"zp_lo",     4'd1, -32'sd1000,        8'h80};
    vecs[9]  = '{"half_p",    4'd4,  32'd100,          8'd23};
    vecs[10] = '{"half_n",    4'd4, -32'sd100,         8'hFD};
    vecs[11] = '{"clamp_hi",  4'd2,  32'd100000,       8'd127};
    vecs[12] = '{"clamp_lo",  4'd2, -32'sd100000,      8'h80};
    vecs[13] = '{"ch15",      4'd15, 32'd1000,         8'd4};

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
    in_valid = 1'b0; in_acc = '0; in_ch = '0; out_ready = 1'b1;
    mirror_defaults();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    cfg_write(4'd3, 32'h8000_0000, 5'd0, 8'd0);
    cfg_write(4'd1, 32'd2014687024, 5'd0, 8'h80);
    cfg_write(4'd4, 32'h4000_0000, 5'd2, 8'd10);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i].name, vecs[i].ch, vecs[i].acc, vecs[i].exp_q);
    end

    // Config write in the same cycle as the read: old entry applies
    in_valid = 1'b1; in_ch = 4'd5; in_acc = 32'd1000;
    cfg_we = 1'b1; cfg_ch = 4'd5; cfg_mult = 32'h4000_0000; cfg_shift = 5'd8; cfg_zp = 8'd20;
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    m_mult[5] = 32'h4000_0000; m_shift[5] = 8; m_zp[5] = 8'd20;
    wait_out("cfg_same_cyc", 4'd5, 8'd4);
    run_vec("cfg_next", 4'd5, 32'd1000, 8'd22);
    tick(); tick();

    // Back-pressure stream with a bench model of the stage valids
    vm = '0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        in_valid = 1'b1;
        in_ch    = 4'(sent % 4);
        in_acc   = 32'(sent * 2311 - 20000);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_en = !vm[3] || out_ready;
      check("bp_in_ready", 64'(in_ready), 64'(exp_en));
      check("bp_out_valid", 64'(out_valid), 64'(vm[3]));
      if (in_valid && exp_en) begin
        exp_q.push_back(model(in_acc, in_ch));
        exp_ch.push_back(in_ch);
        sent++;
      end
      if (vm[3] && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_extra", 64'd1, 64'd0);
        end else begin
          check("bp_q", 64'(out_q), 64'(exp_q.pop_front()));
          check("bp_ch", 64'(out_ch), 64'(exp_ch.pop_front()));
        end
        got++;
      end
      if (exp_en) vm = {vm[2:0], in_valid};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd20);
    tick(); tick(); tick(); tick(); tick();

    // Reset with samples in flight
    cfg_write(4'd0, 32'h4000_0000, 5'd0, 8'd5);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_ch = 4'd0; in_acc = 32'd1000;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_q", 64'(out_q), 64'd0);
    tick(); tick();
    rst = 1'b0;
    mirror_defaults();
    bad_drop = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) bad_drop++;
    end
    check("rst_dropped", 64'(bad_drop), 64'd0);
    run_vec("rst_default", 4'd0, 32'd1000, model(32'd1000, 4'd0));
    check("rst_default_const", 64'(model(32'd1000, 4'd0)), 64'd4);

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
